ex_mem_reg: RTL
===============

Name: ex_mem_reg

Overview:
- EX/MEM pipeline stage directly downstream of the 64-bit ALU.
- Captures ALU result, zero flag, store data, destination register and memory/writeback control bits; resolves conditional branches from the zero flag; presents one beat per cycle to the memory stage.
- Elastic valid/ready handshake with a 2-entry skid: in_ready is purely registered, so no combinational ready path runs back into EX.
- Supports pipeline flush and a saturating back-pressure counter.

Parameters:
- XLEN, 64, datapath width (ALU result, store data, branch target).
- REGW, 5, register index width.
- CNTW, 32, width of stall counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  EX beat valid.
- in_ready  output  1  stage can accept a beat (registered).
- alu_result  input  XLEN  ALU result.
- zero  input  1  ALU zero flag.
- rs2_data  input  XLEN  store data.
- rd  input  REGW  destination register.
- reg_write, mem_read, mem_write, mem_to_reg, branch  input  1 each  control bits.
- branch_target  input  XLEN  computed PC+imm.
- flush  input  1  discard all held and incoming beats.
- out_valid  output  1  MEM beat valid.
- out_ready  input  1  MEM stage accepts.
- out_alu_result, out_rs2_data, out_branch_target  output  XLEN  registered payload.
- out_rd  output  REGW  registered payload.
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  output  1 each  registered payload.
- out_branch_taken  output  1  branch && zero, captured with the beat.
- stall_cycles  output  CNTW  saturating count of cycles with out_valid && !out_ready.

Behaviour:
- Reset (async, active-high): state EMPTY; out_valid=0, in_ready=1, all payload outputs 0, stall_cycles=0. Reset mid-operation drops all held beats immediately.
- Beat transfer:
  - Accept when in_valid && in_ready.
  - Emit when out_valid && out_ready.
  - Latency 1 cycle from accept to out_valid when EMPTY.
- Branch resolution: out_branch_taken = branch & zero, evaluated at accept time and stored in the payload.
- Storage: main register (drives the outputs) and skid register.
- State machine:
  - EMPTY: accept → ONE (load main).
  - ONE:
    - accept && emit → ONE (main reloaded).
    - accept && !emit → TWO (load skid).
    - emit && !accept → EMPTY.
    - neither → hold.
  - TWO: in_ready=0; emit → ONE (main←skid); otherwise hold.
- Ordering is strictly FIFO. Payload is never modified while held.
- in_ready = (state != TWO), registered.
- Flush:
  - Next state EMPTY; out_valid=0 next cycle.
  - A beat presented in the same cycle is dropped. It counts as accepted if in_ready=1, and upstream must not retry it.
  - Flush has priority over accept and emit. An emit in the flush cycle still completes normally.
- stall_cycles: increments on out_valid && !out_ready, saturates at all-ones, unaffected by flush, cleared only by reset.
- Payload outputs hold their last value when out_valid=0. No X on outputs after reset.

Decomposition:
- Shared package riscv_pkg:
  - ex_mem_t packed struct (all payload fields incl. branch_taken).
  - XLEN/REGW constants.
  - ALU op encodings used by EX: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12.
- Natural sub-module: pipe_skid_buf, a generic 2-entry skid buffer parameterised by payload type/width.
  - Owns the state machine, valid/ready and flush.
  - ex_mem_reg wraps it, packs ex_mem_t, computes branch_taken and adds stall_cycles.

Test Plan:
- ADD 64+100: alu_result=164, rd=5, reg_write=1, out_ready=1 → out_valid next cycle, out_alu_result=164, out_rd=5, stall_cycles=0.
- Branch: SUB 64-64 → zero=1, branch=1, target=0x1000 → out_branch_taken=1, out_branch_target=0x1000. Repeat with SLT 4<5 (result=1, zero=0) → out_branch_taken=0.
- Back-pressure:
  - out_ready=0; push A (0xFF), B (0xFFFFFFFF) → in_ready=0 after B; C held upstream.
  - stall_cycles counts each cycle.
  - Raise out_ready → A, B, C emitted in order on consecutive cycles; in_ready returns to 1 one cycle after A leaves.
- Flush: with two beats held (TWO), assert flush with in_valid=1 (NOR 0|0 result 0xFFFF_FFFF_FFFF_FFFF) → out_valid=0 next cycle, in_ready=1, incoming beat never appears at output.
- Async reset mid-operation: reset asserted between clock edges while TWO → out_valid=0, in_ready=1, stall_cycles=0 immediately, before the next clk edge.
- Saturation: force stall with CNTW=4 for 20 cycles → stall_cycles=15, holds at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: datapath widths, ALU op encodings and the
// EX/MEM payload record carried between the execute and memory stages.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int REGW = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] branch_target;
        logic [REGW-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch_taken;
    } ex_mem_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Branch outcome is fixed when the beat is captured, never re-evaluated later.
    function automatic ex_mem_t pack_ex_mem(
        input logic [XLEN-1:0] alu_result,
        input logic            zero,
        input logic [XLEN-1:0] rs2_data,
        input logic [REGW-1:0] rd,
        input logic            reg_write,
        input logic            mem_read,
        input logic            mem_write,
        input logic            mem_to_reg,
        input logic            branch,
        input logic [XLEN-1:0] branch_target
    );
        ex_mem_t pkt;
        pkt.alu_result    = alu_result;
        pkt.rs2_data      = rs2_data;
        pkt.branch_target = branch_target;
        pkt.rd            = rd;
        pkt.reg_write     = reg_write;
        pkt.mem_read      = mem_read;
        pkt.mem_write     = mem_write;
        pkt.mem_to_reg    = mem_to_reg;
        pkt.branch_taken  = branch & zero;
        return pkt;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid register
// absorbs the one beat that can arrive while ready is still registered high.
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    import riscv_pkg::*;

    skid_state_e      state;
    skid_state_e      state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             valid_q;
    logic             ready_q;
    logic             accept;
    logic             emit;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign accept = in_valid && ready_q;
    assign emit   = valid_q && out_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Incoming beat is swallowed; an emit this cycle still completes downstream.
            state_next = SKID_EMPTY;
        end else begin
            unique case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_next   = SKID_ONE;
                        load_main_in = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (accept && emit) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next = SKID_TWO;
                        load_skid  = 1'b1;
                    end else if (emit) begin
                        state_next = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (emit) begin
                        state_next     = SKID_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = SKID_EMPTY;
            endcase
        end
    end

    // valid/ready are flops of the next state so neither has a combinational path.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state   <= SKID_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            valid_q <= (state_next != SKID_EMPTY);
            ready_q <= (state_next != SKID_TWO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: payload storage is reset too, so outputs are never X after reset.
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: packs the ALU beat, resolves the branch at capture
// time, buffers it through an elastic skid stage and counts back-pressure cycles.
module ex_mem_reg #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            zero,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [REGW-1:0] rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_branch_target,
    output logic [REGW-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_mem_to_reg,
    output logic            out_branch_taken,
    output logic [CNTW-1:0] stall_cycles
);
    import riscv_pkg::*;

    ex_mem_t         in_pkt;
    ex_mem_t         out_pkt;
    logic [CNTW-1:0] stall_q;

    assign in_pkt = pack_ex_mem(alu_result, zero, rs2_data, rd, reg_write, mem_read,
                                mem_write, mem_to_reg, branch, branch_target);

    pipe_skid_buf #(
        .WIDTH (EX_MEM_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pkt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pkt)
    );

    // Saturating counter; flush deliberately leaves it alone so stalls stay visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNTW'(1);
        end
    end

    assign stall_cycles      = stall_q;
    assign out_alu_result    = out_pkt.alu_result;
    assign out_rs2_data      = out_pkt.rs2_data;
    assign out_branch_target = out_pkt.branch_target;
    assign out_rd            = out_pkt.rd;
    assign out_reg_write     = out_pkt.reg_write;
    assign out_mem_read      = out_pkt.mem_read;
    assign out_mem_write     = out_pkt.mem_write;
    assign out_mem_to_reg    = out_pkt.mem_to_reg;
    assign out_branch_taken  = out_pkt.branch_taken;

endmodule
